// File: rtl/uart_pkg.sv
// Shared UART definitions (frame levels, data width, FSM states) for the transmitter and receiver.
package uart_pkg;

  localparam int   DATA_WIDTH  = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit for one byte: par_typ 0 = even (XOR of bits), 1 = odd (XNOR of bits).
// Combinational, zero latency; no flow control.
module uart_parity_calc
  import uart_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one bit per CLK, frame = start, 8 data LSB first, [parity], stop; parity built only with UART_TX_PARITY_EN.
// Latency: START on the line the cycle after acceptance; requests are dropped (not queued) while busy.
module uart_tx
  import uart_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            bit_idx;
  logic [2:0]            bit_idx_nxt;

  assign bit_idx_nxt = bit_idx + 3'd1;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
  logic par_bit;

  uart_parity_calc u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );
`else
  logic unused_par_cfg;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

  // Outputs are registered alongside the state, so TX_OUT always matches the current state's bit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      TX_OUT  <= IDLE_LEVEL;
      busy    <= 1'b0;
      bit_idx <= 3'd0;
      data_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= IDLE_LEVEL;
          busy   <= 1'b0;
          if (Data_Valid) begin
            data_q <= P_DATA;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
`endif
            state  <= START;
            TX_OUT <= START_LEVEL;
            busy   <= 1'b1;
          end
        end
        START: begin
          state   <= DATA;
          TX_OUT  <= data_q[0];
          bit_idx <= 3'd0;
        end
        DATA: begin
          bit_idx <= bit_idx_nxt;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par_bit;
            end else begin
              state  <= STOP;
              TX_OUT <= STOP_LEVEL;
            end
`else
            state  <= STOP;
            TX_OUT <= STOP_LEVEL;
`endif
          end else begin
            TX_OUT <= data_q[bit_idx_nxt];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_LEVEL;
        end
`endif
        STOP: begin
          state  <= IDLE;
          TX_OUT <= IDLE_LEVEL;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= IDLE_LEVEL;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line/busy values are queued per cycle at request time and compared on negedges.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       busy;

  typedef struct packed {
    logic tx;
    logic bsy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Expected frame: start 0, data LSB first, optional parity, stop 1, busy high throughout.
  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
    exp_t e;
    e.bsy = 1'b1;
    e.tx  = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.tx = d[i];
      exp_q.push_back(e);
    end
`ifdef UART_TX_PARITY_EN
    if (pe) begin
      e.tx = pt ? ~(^d) : (^d);
      exp_q.push_back(e);
    end
`else
    if (pe ^ pt) e.tx = 1'b1;
`endif
    e.tx = 1'b1;
    exp_q.push_back(e);
  endfunction

  // Present a request at a negedge; returns at the negedge of the START cycle.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt, input logic keep_vld);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    push_frame(d, pe, pt);
    @(negedge CLK);
    if (!keep_vld) Data_Valid = 1'b0;
  endtask

  // kind 1: drop Data_Valid at index act_at; kind 2: pulse Data_Valid with 0xFF at act_at.
  task automatic drain(input string name, input int act_at, input int kind);
    exp_t e;
    int   i;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (TX_OUT !== e.tx || busy !== e.bsy) begin
        n_err++;
        $display("FAIL %s cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=%b",
                 name, i, TX_OUT, busy, e.tx, e.bsy);
      end
      if (kind == 1 && i == act_at) Data_Valid = 1'b0;
      if (kind == 2 && i == act_at) begin
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        Data_Valid = 1'b1;
      end
      if (kind == 2 && i == act_at + 1) Data_Valid = 1'b0;
      @(negedge CLK);
      i++;
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      n_cmp++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle %0d: TX_OUT=%b busy=%b, expected TX_OUT=1 busy=0",
                 name, i, TX_OUT, busy);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_idle("reset_held", 1);
    RST = 1'b1;
    check_idle("post_reset_no_req", 4);
  endtask

  task automatic test_no_parity();
    start_frame(8'hB2, 1'b0, 1'b0, 1'b0);
    drain("b2_nopar", 0, 0);
    check_idle("b2_nopar_after", 2);
  endtask

  task automatic test_parity();
    start_frame(8'hB2, 1'b1, 1'b0, 1'b0);
    drain("b2_even", 0, 0);
    check_idle("b2_even_after", 1);
    start_frame(8'hB2, 1'b1, 1'b1, 1'b0);
    drain("b2_odd", 0, 0);
    check_idle("b2_odd_after", 1);
  endtask

  task automatic test_back_to_back();
    exp_t idle_e;
    int   len_a;
    idle_e.tx  = 1'b1;
    idle_e.bsy = 1'b0;
    start_frame(8'hB2, 1'b1, 1'b0, 1'b1);
    P_DATA = 8'hA4;
    len_a = exp_q.size() + 1;
    exp_q.push_back(idle_e);
    push_frame(8'hA4, 1'b1, 1'b0);
    drain("b2_a4_b2b", len_a + 1, 1);
    check_idle("b2_a4_after", 3);
  endtask

  task automatic test_ignore_busy();
    start_frame(8'hB2, 1'b0, 1'b0, 1'b0);
    drain("ignore_ff", 3, 2);
    check_idle("ignore_ff_after", 4);
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    start_frame(8'hB2, 1'b0, 1'b0, 1'b0);
    // Cycles 0..5 are start and data bits 0..4; reset is asserted during data bit 4.
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (TX_OUT !== e.tx || busy !== e.bsy) begin
        n_err++;
        $display("FAIL rst_mid cycle %0d: TX_OUT=%b busy=%b, expected TX_OUT=%b busy=%b",
                 i, TX_OUT, busy, e.tx, e.bsy);
      end
      if (i == 5) RST = 1'b0;
      @(negedge CLK);
    end
    exp_q.delete();
    check_idle("rst_mid_abort", 1);
    RST = 1'b1;
    check_idle("rst_mid_no_resume", 3);
    start_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    drain("after_rst_5a", 0, 0);
    check_idle("after_rst_idle", 2);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
